// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, req/ack data-memory access FSM with timeout,
// byte-lane store replication and load extraction/extension.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic [1:0]  MemSizeE,
  input  logic        MemSignedE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  output logic [31:0] ALUOutMOut,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  wait_cnt;
  logic        timeout;
  logic        aligned_op_e;

  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic [31:0] alu_out;
  logic [31:0] write_data;
  logic [4:0]  write_reg;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = addr[0];
      default: is_misaligned = (addr != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'b00:   lane_enables = 4'b0001 << addr;
      2'b01:   lane_enables = addr[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   replicate = {4{data[7:0]}};
      2'b01:   replicate = {2{data[15:0]}};
      default: replicate = data;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic sgn,
                                          input logic [1:0] addr, input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    h = 16'h0000;
    case (size)
      2'b00: begin
        case (addr)
          2'b00:   b = data[7:0];
          2'b01:   b = data[15:8];
          2'b10:   b = data[23:16];
          default: b = data[31:24];
        endcase
        extract = {{24{sgn & b[7]}}, b};
      end
      2'b01: begin
        h = addr[1] ? data[31:16] : data[15:0];
        extract = {{16{sgn & h[15]}}, h};
      end
      default: extract = data;
    endcase
  endfunction

  assign aligned_op_e = (MemReadE | MemWriteE) & ~is_misaligned(MemSizeE, ALUOutE[1:0]);
  assign timeout      = (state == ACCESS) & ~dmem_ack & (wait_cnt == LAST_WAIT);

  // EX/MEM pipeline register: loads whenever the stage is not stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_size   <= 2'b00;
      mem_signed <= 1'b0;
      alu_out    <= 32'h0000_0000;
      write_data <= 32'h0000_0000;
      write_reg  <= 5'd0;
    end else if (!StallM) begin
      reg_write  <= RegWriteE;
      mem_to_reg <= MemtoRegE;
      mem_read   <= MemReadE;
      mem_write  <= MemWriteE;
      mem_size   <= MemSizeE;
      mem_signed <= MemSignedE;
      alu_out    <= ALUOutE;
      write_data <= WriteDataE;
      write_reg  <= WriteRegE;
    end
  end

  // State register and wait counter; the counter restarts whenever a new instruction loads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= StallM ? (wait_cnt + 8'd1) : 8'd0;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = aligned_op_e ? ACCESS : IDLE;
      ACCESS: begin
        if (StallM) begin
          next_state = ACCESS;
        end else begin
          next_state = aligned_op_e ? ACCESS : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Stage outputs; an ack in the same cycle beats the timeout
  always_comb begin
    StallM     = 1'b0;
    BusErrM    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = 32'h0000_0000;
    ReadDataM  = 32'h0000_0000;
    MisalignM  = (mem_read | mem_write) & is_misaligned(mem_size, alu_out[1:0]);
    case (state)
      ACCESS: begin
        StallM   = ~dmem_ack & ~timeout;
        BusErrM  = timeout;
        dmem_req = 1'b1;
        dmem_we  = mem_write;
        dmem_be  = lane_enables(mem_size, alu_out[1:0]);
        if (mem_write) begin
          dmem_wdata = replicate(mem_size, write_data);
        end else begin
          dmem_wdata = 32'h0000_0000;
        end
        if (dmem_ack) begin
          ReadDataM = extract(mem_size, mem_signed, alu_out[1:0], dmem_rdata);
        end else begin
          ReadDataM = 32'h0000_0000;
        end
      end
      default: begin
        StallM = 1'b0;
      end
    endcase
    RegWriteM = reg_write & ~StallM & ~MisalignM & ~BusErrM;
  end

  assign ALUOutMOut = alu_out;
  assign WriteRegM  = write_reg;
  assign MemtoRegM  = mem_to_reg;
  assign dmem_addr  = {alu_out[31:2], 2'b00};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Pipeline stage directly downstream of the execute stage. It holds the EX/MEM pipeline register and drives a req/ack data-memory bus. Loads are byte-lane selected and extended; stores are lane-replicated with byte enables. It stalls the pipeline while a memory access is outstanding. It supplies the MEM/WB stage and provides the ALU-result forwarding path back to execute.

Parameters:
TIMEOUT, 255, max cycles an access waits for dmem_ack before abort (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
RegWriteE  in  1  EX instr writes register file
MemtoRegE  in  1  EX instr writeback selects load data
MemReadE  in  1  EX instr is a load
MemWriteE  in  1  EX instr is a store
MemSizeE  in  2  00 byte, 01 half, 10 word (11 treated as word)
MemSignedE  in  1  1 = sign-extend load, 0 = zero-extend
ALUOutE  in  32  effective address / ALU result from execute
WriteDataE  in  32  store data (forwarded rt) from execute
WriteRegE  in  5  destination register from execute
ALUOutMOut  out  32  registered ALU result; forwarding source for execute
WriteRegM  out  5  registered destination register
RegWriteM  out  1  registered RegWrite, gated (see Behaviour)
MemtoRegM  out  1  registered MemtoReg
ReadDataM  out  32  extended load data, valid in ack cycle
StallM  out  1  to hazard unit: freeze PC, IF/ID, ID/EX and this stage
MisalignM  out  1  current M instr is misaligned, access dropped
BusErrM  out  1  one-cycle pulse: access aborted on timeout
dmem_req  out  1  access request
dmem_we  out  1  1 = write
dmem_addr  out  32  {ALUOutMOut[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid when dmem_ack=1
dmem_ack  in  1  access complete this cycle

Behaviour:
- Reset (rst_n=0 at posedge): all EX/MEM register fields, state and counter cleared to 0; FSM=IDLE. Outputs all 0, including dmem_req, StallM, MisalignM and BusErrM.
- EX/MEM register loads every posedge with StallM=0 and holds while StallM=1.
- Register fields: RegWrite, MemtoReg, MemRead, MemWrite, MemSize, MemSigned, ALUOut, WriteData, WriteReg.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0, while MemRead|MemWrite.
  - MisalignM=1 while the instruction sits in M.
  - No dmem_req; RegWriteM forced 0; store discarded; no stall.
- FSM IDLE/ACCESS:
  - Next state is ACCESS when the register loads an aligned memory op; otherwise IDLE.
  - In ACCESS, dmem_req=1 and dmem_we=MemWrite.
  - When dmem_ack=1: the access completes, StallM=0 and the register loads the next instruction. The FSM stays in ACCESS if that instruction is also an aligned memory op.
- StallM = (state==ACCESS) & ~dmem_ack & ~timeout. A zero-wait memory that acks in the first ACCESS cycle causes no stall.
- Timeout counter:
  - Cleared on entry to ACCESS; increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT-1 with no ack: BusErrM pulses for that cycle, StallM=0, RegWriteM=0 and the access is abandoned.
  - ack in the same cycle takes priority over timeout.
- RegWriteM = reg.RegWrite & ~StallM & ~MisalignM & ~BusErrM, so a stalled instruction presents a bubble to MEM/WB.
- Byte enables by size (dmem_be identical for loads and stores):
  - Byte: be = 4'b0001<<addr[1:0]; wdata = {4{WriteData[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{WriteData[15:0]}}.
  - Word: be = 1111; wdata = WriteData.
- Load extraction: lane selected by addr[1:0] for byte, addr[1] for half; extended per MemSigned; word passes through.
- ReadDataM: combinational from dmem_rdata. Outside ack cycles it is 0.
- Non-memory instructions pass through in one cycle; ALUOutMOut is valid the cycle after capture.
- Reset asserted mid-ACCESS: FSM returns to IDLE and dmem_req drops on the next edge. The pending access is lost; no BusErrM.

Test Plan:
1. Zero-wait ack tied to 1: lw from 0x100 with rdata=0xDEADBEEF. Expect ReadDataM=0xDEADBEEF, RegWriteM=1, StallM never 1.
2. lb signed from 0x103 with rdata=0x80112233. Expect ReadDataM=0xFFFFFF80. lbu from the same address -> 0x00000080. lh from 0x102 signed -> 0xFFFF8011.
3. sb 0xA5 to 0x201. Expect dmem_be=0010, dmem_wdata=0xA5A5A5A5, dmem_addr=0x200, dmem_we=1. sh to 0x202 -> be=1100.
4. ack delayed 3 cycles on lw. Expect StallM=1 for 3 cycles, register held with ALUOutMOut stable, RegWriteM=0 during the stall and 1 in the ack cycle.
5. TIMEOUT=4, ack never asserted. Expect StallM=1 for 3 cycles, then BusErrM pulses once with StallM=0 and RegWriteM=0; the next instruction loads.
6. lw to 0x102 -> MisalignM=1, dmem_req=0, RegWriteM=0, no stall. Separately, assert rst_n=0 mid-stall -> all outputs 0 on the next edge.
